// File: rtl/imm_ext_pipe_if.sv
// Request/result bundle for imm_ext_pipe; prefix signals exist only when IMM_PREFIX_EN is defined.
interface imm_ext_pipe_if #(
  parameter int DATA_W = 16,
  parameter int F0_W   = 10,
  parameter int F1_W   = 4,
  parameter int F2_W   = 6,
  parameter int F3_W   = 8,
  parameter int PFX_LO = 4
);
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        sel;
  logic [1:0]        mode;
  logic [F0_W-1:0]   in0;
  logic [F1_W-1:0]   in1;
  logic [F2_W-1:0]   in2;
  logic [F3_W-1:0]   in3;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] ext_out;
`ifdef IMM_PREFIX_EN
  logic                     prefix_load;
  logic [DATA_W-PFX_LO-1:0] prefix_val;
  logic                     pfx_used;

  modport master (
    output in_valid, sel, mode, in0, in1, in2, in3, out_ready, prefix_load, prefix_val,
    input  in_ready, out_valid, ext_out, pfx_used
  );
  modport slave (
    input  in_valid, sel, mode, in0, in1, in2, in3, out_ready, prefix_load, prefix_val,
    output in_ready, out_valid, ext_out, pfx_used
  );
`else
  modport master (
    output in_valid, sel, mode, in0, in1, in2, in3, out_ready,
    input  in_ready, out_valid, ext_out
  );
  modport slave (
    input  in_valid, sel, mode, in0, in1, in2, in3, out_ready,
    output in_ready, out_valid, ext_out
  );
`endif
endinterface

// File: rtl/imm_ext_pipe.sv
// Registered immediate generator (sext / zext / sext<<SHIFT_AMT / upper) with valid/ready output.
// Define IMM_PREFIX_EN to build the long-immediate prefix register and its IDLE/PFX FSM.
module imm_ext_pipe #(
  parameter int DATA_W    = 16,
  parameter int F0_W      = 10,
  parameter int F1_W      = 4,
  parameter int F2_W      = 6,
  parameter int F3_W      = 8,
  parameter int SHIFT_AMT = 1,
  parameter int PFX_LO    = 4
) (
  input  logic          clk,
  input  logic          rst,
  imm_ext_pipe_if.slave bus
);

  function automatic int field_w(int idx);
    if (idx == 0) return F0_W;
    else if (idx == 1) return F1_W;
    else if (idx == 2) return F2_W;
    else return F3_W;
  endfunction

  localparam logic [DATA_W-1:0] ONE = 1;

  generate
    if (F0_W > DATA_W || F1_W > DATA_W || F2_W > DATA_W || F3_W > DATA_W) begin : g_bad_width
      $error("imm_ext_pipe: a field width exceeds DATA_W");
    end
`ifdef IMM_PREFIX_EN
    if (PFX_LO < 1 || PFX_LO > F0_W || PFX_LO > F1_W || PFX_LO > F2_W || PFX_LO > F3_W) begin : g_bad_pfx
      $error("imm_ext_pipe: PFX_LO must be within 1..min field width");
    end
`endif
  endgenerate

  logic [3:0][DATA_W-1:0] zext_val;
  logic [3:0][DATA_W-1:0] sext_val;
  logic [3:0][DATA_W-1:0] upper_val;

  assign zext_val[0] = DATA_W'(bus.in0);
  assign zext_val[1] = DATA_W'(bus.in1);
  assign zext_val[2] = DATA_W'(bus.in2);
  assign zext_val[3] = DATA_W'(bus.in3);

  // HI_MASK covers the bits above the field; it is zero when the field fills DATA_W.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_field
      localparam int W = field_w(gi);
      localparam logic [DATA_W-1:0] HI_MASK = ~((ONE << W) - ONE);
      assign sext_val[gi]  = zext_val[gi] | (zext_val[gi][W-1] ? HI_MASK : '0);
      assign upper_val[gi] = zext_val[gi] << (DATA_W - W);
    end
  endgenerate

  logic              accept;
  logic              take;
  logic              use_pfx;
  logic [DATA_W-1:0] fld_z;
  logic [DATA_W-1:0] fld_s;
  logic [DATA_W-1:0] fld_u;
  logic [DATA_W-1:0] result;

  logic              valid_reg;
  logic [DATA_W-1:0] ext_reg;
  logic              pfx_used_reg;

  assign bus.in_ready  = !valid_reg || bus.out_ready;
  assign accept        = bus.in_valid && bus.in_ready;
  assign take          = valid_reg && bus.out_ready;
  assign bus.out_valid = valid_reg;
  assign bus.ext_out   = ext_reg;

`ifdef IMM_PREFIX_EN
  typedef enum logic {IDLE, PFX} state_t;

  state_t                   state_reg;
  state_t                   state_next;
  logic [DATA_W-PFX_LO-1:0] prefix_reg;
  logic [DATA_W-PFX_LO-1:0] prefix_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      prefix_reg <= '0;
    end else begin
      state_reg  <= state_next;
      prefix_reg <= prefix_next;
    end
  end

  // A load coinciding with an accept lands after the accepted request consumed the old state.
  always_comb begin
    state_next  = state_reg;
    prefix_next = prefix_reg;
    if (accept && state_reg == PFX) state_next = IDLE;
    if (bus.prefix_load) begin
      prefix_next = bus.prefix_val;
      state_next  = PFX;
    end
  end

  assign use_pfx      = (state_reg == PFX);
  assign bus.pfx_used = pfx_used_reg;
`else
  assign use_pfx = 1'b0;
`endif

  always_comb begin
    fld_z = zext_val[bus.sel];
    fld_s = sext_val[bus.sel];
    fld_u = upper_val[bus.sel];
    case (bus.mode)
      2'd0:    result = fld_s;
      2'd1:    result = fld_z;
      2'd2:    result = fld_s << SHIFT_AMT;
      default: result = fld_u;
    endcase
`ifdef IMM_PREFIX_EN
    if (use_pfx) result = {prefix_reg, fld_z[PFX_LO-1:0]};
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_reg    <= 1'b0;
      ext_reg      <= '0;
      pfx_used_reg <= 1'b0;
    end else if (accept) begin
      valid_reg    <= 1'b1;
      ext_reg      <= result;
      pfx_used_reg <= use_pfx;
    end else if (take) begin
      valid_reg    <= 1'b0;
    end
  end

endmodule
